mem_lsu: RTL and testbench
==========================

MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 SHALL have parameter AW, default 32: byte address width.
REQ-002 SHALL have parameter DW, default 32: data width; only 32 supported.
REQ-003 SHALL have one clock and an asynchronous, active-high reset.
REQ-004 SHALL have port clk  input  1  clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port req_valid  input  1  access request present.
REQ-007 SHALL have port req_ready  output  1  request accepted when high with req_valid.
REQ-008 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-009 SHALL have port req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
REQ-010 SHALL have port req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-011 SHALL have port req_addr  input  AW  byte address.
REQ-012 SHALL have port req_wdata  input  DW  store data, right-aligned.
REQ-013 SHALL have port rsp_valid  output  1  response present.
REQ-014 SHALL have port rsp_ready  input  1  response consumed when high with rsp_valid.
REQ-015 SHALL have port rsp_rdata  output  DW  extended load data; 0 for stores and errors.
REQ-016 SHALL have port rsp_err  output  1  misaligned or illegal-size access.
REQ-017 SHALL have port mem_wen  output  4  per-byte write enables to the byte-lane RAM.
REQ-018 SHALL have port mem_ren  output  1  read enable to the RAM.
REQ-019 SHALL have port mem_addr  output  AW  byte address; the RAM divides it by 4.
REQ-020 SHALL have port mem_wdata  output  DW  lane-replicated store data.
REQ-021 SHALL have port mem_rdata  input  DW  RAM read data, valid exactly 1 cycle after mem_ren.

Function
REQ-022 SHALL implement FSM IDLE, ISSUE, CAPTURE, RESP; req_ready=1 only in IDLE.
REQ-023 On accept: misaligned (half with addr[0]=1; word with addr[1:0]!=0; size=3) SHALL go IDLE->RESP with rsp_err=1, rsp_rdata=0, and no mem strobe.
REQ-024 On accept when aligned: SHALL go IDLE->ISSUE, registering addr, size, unsigned, we, and lane-formatted data.
REQ-025 ISSUE SHALL last 1 cycle, driving mem_wen (store) or mem_ren (load) for exactly that cycle; all strobes are 0 in every other state.
REQ-026 Store wen SHALL be: byte 4'b0001<<addr[1:0]; half 4'b0011<<(2*addr[1]); word 4'b1111.
REQ-027 Store wdata SHALL be: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
REQ-028 Store SHALL go ISSUE->RESP; load SHALL go ISSUE->CAPTURE->RESP.
REQ-029 CAPTURE SHALL register (mem_rdata >> 8*addr[1:0]), truncated to size and extended per req_unsigned.
REQ-030 RESP SHALL hold rsp_valid=1 and stable data until rsp_ready, then SHALL go to IDLE; a request cannot be accepted in that same cycle.
REQ-031 Latency accept->rsp_valid SHALL be 1 cycle (error), 2 (store), or 3 (load).
REQ-032 mem_addr SHALL hold the last issued address outside ISSUE.

Reset
REQ-033 rst SHALL force IDLE and clear rsp_valid, rsp_err, rsp_rdata, mem_wen, mem_ren, mem_addr, and mem_wdata to 0 immediately.
REQ-034 rst asserted mid-transaction SHALL abort it: no strobe after rst rises, and no response is produced.

Structure
REQ-035 Package mem_pkg SHALL hold the size encodings (SZ_B/SZ_H/SZ_W) and the FSM state enum.
REQ-036 The load align/extend logic SHALL be a combinational sub-module lsu_load_ext (rdata, offset, size, unsigned -> data).

Verification
REQ-037 Store word 0xDEADBEEF @0x10 -> ISSUE cycle: wen=1111, addr=0x10, wdata=0xDEADBEEF; rsp_valid 2 cycles after accept, err=0.
REQ-038 Store byte 0xA5 @0x13, then load byte signed @0x13 -> wen=1000, wdata=0xA5A5A5A5; load rsp_rdata=0xFFFFFFA5 at 3-cycle latency.
REQ-039 Load half unsigned @0x12 with RAM word 0x8001_7FFF -> rsp_rdata=0x00008001; signed -> 0xFFFF8001.
REQ-040 Load word @0x11, half @0x03, and size=3 @0x00 -> each gives rsp_err=1 and rsp_rdata=0 one cycle after accept; mem_wen and mem_ren stay 0.
REQ-041 rsp_ready held low 5 cycles -> rsp_valid and rsp_rdata stay stable and req_ready=0 throughout; IDLE follows the handshake.
REQ-042 rst pulsed during ISSUE of a store -> strobes drop asynchronously, no rsp_valid, req_ready=1 after release.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and lane-formatting helpers for the load/store unit.
package mem_pkg;

    localparam int unsigned LANES  = 4;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = LANES * BYTE_W;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_X = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } state_e;

    // Attributes of the accepted request that outlive the handshake.
    typedef struct packed {
        logic  we;
        size_e size;
        logic  uns;
    } req_attr_t;

    function automatic logic misaligned(size_e size, logic [1:0] off);
        logic bad;
        case (size)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = off[0];
            SZ_W:    bad = (off != 2'd0);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [LANES-1:0] store_wen(size_e size, logic [1:0] off);
        logic [LANES-1:0] wen;
        case (size)
            SZ_B:    wen = 4'b0001 << off;
            SZ_H:    wen = 4'b0011 << {off[1], 1'b0};
            default: wen = 4'b1111;
        endcase
        return wen;
    endfunction

    function automatic logic [WORD_W-1:0] store_wdata(size_e size, logic [WORD_W-1:0] wd);
        logic [WORD_W-1:0] lanes;
        case (size)
            SZ_B:    lanes = {4{wd[7:0]}};
            SZ_H:    lanes = {2{wd[15:0]}};
            default: lanes = wd;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Aligns a RAM word to the addressed byte and truncates/extends to the load size.
module lsu_load_ext
    import mem_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  offset_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [31:0] data_c_o
);

    logic [31:0] shifted;
    logic        sign_b;
    logic        sign_h;

    assign shifted = rdata_i >> {offset_i, 3'b000};
    assign sign_b  = ~unsigned_i & shifted[7];
    assign sign_h  = ~unsigned_i & shifted[15];

    always_comb begin
        data_c_o = shifted;
        case (size_e'(size_i))
            SZ_B:    data_c_o = {{24{sign_b}}, shifted[7:0]};
            SZ_H:    data_c_o = {{16{sign_h}}, shifted[15:0]};
            default: data_c_o = shifted;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// Single-outstanding load/store unit in front of a byte-lane RAM with 1-cycle read latency.
module mem_lsu
    import mem_pkg::*;
#(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [1:0]    req_size,
    input  logic          req_unsigned,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic [3:0]    mem_wen,
    output logic          mem_ren,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    state_e        state_q, state_d;
    req_attr_t     attr_q, attr_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]    mem_wen_q, mem_wen_d;
    logic          mem_ren_q, mem_ren_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          rsp_err_q, rsp_err_d;
    logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
    logic          req_ready_q, req_ready_d;

    logic          accept_c;
    size_e         req_size_c;
    logic          req_bad_c;
    logic [31:0]   load_data_c;

    assign accept_c   = req_valid & req_ready_q;
    assign req_size_c = size_e'(req_size);
    assign req_bad_c  = misaligned(req_size_c, req_addr[1:0]);

    lsu_load_ext u_load_ext (
        .rdata_i    (32'(mem_rdata)),
        .offset_i   (mem_addr_q[1:0]),
        .size_i     (attr_q.size),
        .unsigned_i (attr_q.uns),
        .data_c_o   (load_data_c)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    state_d = req_bad_c ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE:   state_d = attr_q.we ? ST_RESP : ST_CAPTURE;
            ST_CAPTURE: state_d = ST_RESP;
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default:    state_d = ST_IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs, strobes only for the ISSUE cycle.
    always_comb begin
        attr_d      = attr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wen_d   = 4'b0000;
        mem_ren_d   = 1'b0;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        req_ready_d = (state_d == ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    if (req_bad_c) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end else begin
                        attr_d.we   = req_we;
                        attr_d.size = req_size_c;
                        attr_d.uns  = req_unsigned;
                        mem_addr_d  = req_addr;
                        mem_wdata_d = DW'(store_wdata(req_size_c, 32'(req_wdata)));
                        if (req_we) begin
                            mem_wen_d = store_wen(req_size_c, req_addr[1:0]);
                        end else begin
                            mem_ren_d = 1'b1;
                        end
                    end
                end
            end
            ST_ISSUE: begin
                if (attr_q.we) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = '0;
                end
            end
            ST_CAPTURE: begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = DW'(load_data_c);
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = '0;
                end
            end
            default: ;
        endcase
    end

    // Registered outputs and request attributes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            attr_q      <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wen_q   <= 4'b0000;
            mem_ren_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            req_ready_q <= 1'b1;
        end else begin
            attr_q      <= attr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wen_q   <= mem_wen_d;
            mem_ren_q   <= mem_ren_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            req_ready_q <= req_ready_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign mem_wen   = mem_wen_q;
    assign mem_ren   = mem_ren_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: byte-array reference model plus a 256-byte lane RAM.
module tb_mem_lsu;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [1:0]    req_size = 2'd0;
    logic          req_unsigned = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic [3:0]    mem_wen;
    logic          mem_ren;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    always #5 clk = ~clk;

    mem_lsu #(.AW(AW), .DW(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .mem_wen      (mem_wen),
        .mem_ren      (mem_ren),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    // Byte-lane RAM, 1-cycle read latency, address bits above 7 ignored.
    logic [7:0] ram_b [0:255];
    always @(posedge clk) begin
        if (mem_ren)
            mem_rdata <= {ram_b[{mem_addr[7:2], 2'd3}], ram_b[{mem_addr[7:2], 2'd2}],
                          ram_b[{mem_addr[7:2], 2'd1}], ram_b[{mem_addr[7:2], 2'd0}]};
        for (int l = 0; l < 4; l++)
            if (mem_wen[l]) ram_b[{mem_addr[7:2], 2'(l)}] <= mem_wdata[8*l +: 8];
    end

    logic [7:0] ref_mem [0:255];
    int errors = 0;
    int checks = 0;

    logic [3:0]  obs_wen;
    logic        obs_ren;
    logic [31:0] obs_addr, obs_wdata, obs_rdata;
    logic        obs_err, obs_after_valid, obs_after_ready;
    int          obs_lat, obs_stray, obs_unstable, obs_busy;
    bit          obs_timeout;

    logic        e_err;
    logic [31:0] e_rdata, e_wdata;
    logic [3:0]  e_wen;
    int          e_lat;

    // Expected outcome of one access from byte-level semantics; stores update the model.
    task automatic model_expect(input logic we, input logic [1:0] sz, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wd);
        int n;
        logic [31:0] val;
        n = 1 << sz;
        e_err   = (sz == 2'd3) || (sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr[1:0] != 2'd0);
        e_rdata = 32'h0;
        e_wen   = 4'h0;
        e_wdata = 32'h0;
        e_lat   = e_err ? 1 : (we ? 2 : 3);
        if (e_err) return;
        for (int l = 0; l < 4; l++) e_wdata[8*l +: 8] = wd[8*(l % n) +: 8];
        if (we) begin
            for (int i = 0; i < n; i++) begin
                e_wen[(addr + i) % 4] = 1'b1;
                ref_mem[(addr + i) & 255] = wd[8*i +: 8];
            end
        end else begin
            val = 32'h0;
            for (int i = 0; i < n; i++) val = val | (32'(ref_mem[(addr + i) & 255]) << (8 * i));
            if (!uns && n < 4 && val[8*n-1]) val = val | (32'hFFFF_FFFF << (8 * n));
            e_rdata = val;
        end
    endtask

    // Drives one request and records what the DUT did; tests judge the observations.
    task automatic do_access(input logic we, input logic [1:0] sz, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wd, input int hold);
        int cyc;
        bit got;
        obs_wen = 4'h0; obs_ren = 1'b0; obs_addr = '0; obs_wdata = '0;
        obs_rdata = '0; obs_err = 1'b0; obs_lat = 0; obs_stray = 0;
        obs_unstable = 0; obs_busy = 0; obs_timeout = 1'b0;
        obs_after_valid = 1'b1; obs_after_ready = 1'b0;
        req_we = we; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wd;
        req_valid = 1'b1;
        cyc = 0;
        while (req_ready !== 1'b1 && cyc < 20) begin
            @(posedge clk); #1; cyc++;
        end
        if (req_ready !== 1'b1) begin
            obs_timeout = 1'b1; req_valid = 1'b0; return;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_addr = $urandom; req_wdata = $urandom; req_size = 2'($urandom);
        req_we = 1'($urandom); req_unsigned = 1'($urandom);
        got = 1'b0;
        for (cyc = 1; cyc <= 8 && !got; cyc++) begin
            if (req_ready !== 1'b0) obs_busy++;
            if (cyc == 1) begin
                obs_wen = mem_wen; obs_ren = mem_ren; obs_addr = mem_addr; obs_wdata = mem_wdata;
            end else if (mem_wen !== 4'h0 || mem_ren !== 1'b0) begin
                obs_stray++;
            end
            if (rsp_valid === 1'b1) begin
                got = 1'b1; obs_lat = cyc;
            end else begin
                @(posedge clk); #1;
            end
        end
        if (!got) begin
            obs_timeout = 1'b1; return;
        end
        obs_rdata = rsp_rdata;
        obs_err   = rsp_err;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b1 || rsp_rdata !== obs_rdata || rsp_err !== obs_err ||
                req_ready !== 1'b0 || mem_wen !== 4'h0 || mem_ren !== 1'b0)
                obs_unstable++;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        obs_after_valid = rsp_valid;
        obs_after_ready = req_ready;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        checks++;
        if ({rsp_valid, rsp_err, mem_ren, mem_wen} !== 7'h0) begin
            errors++; $display("FAIL reset_strobes: got %b required 0", {rsp_valid, rsp_err, mem_ren, mem_wen});
        end
        checks++;
        if ({rsp_rdata, mem_addr, mem_wdata} !== 96'h0) begin
            errors++; $display("FAIL reset_data: got %h/%h/%h required 0", rsp_rdata, mem_addr, mem_wdata);
        end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got %b required 1", req_ready);
        end
    endtask

    task automatic test_store_word();
        model_expect(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF);
        do_access(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, 0);
        checks++;
        if (obs_wen !== 4'b1111 || obs_ren !== 1'b0) begin
            errors++; $display("FAIL sw_wen: got %b/%b required 1111/0", obs_wen, obs_ren);
        end
        checks++;
        if (obs_addr !== 32'h10 || obs_wdata !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL sw_bus: got %h/%h required 00000010/deadbeef", obs_addr, obs_wdata);
        end
        checks++;
        if (obs_lat !== 2 || obs_err !== 1'b0 || obs_rdata !== 32'h0) begin
            errors++; $display("FAIL sw_rsp: got lat %0d err %b data %h required 2/0/0", obs_lat, obs_err, obs_rdata);
        end
    endtask

    task automatic test_byte();
        model_expect(1'b1, 2'd0, 1'b0, 32'h13, 32'h0000_00A5);
        do_access(1'b1, 2'd0, 1'b0, 32'h13, 32'h0000_00A5, 0);
        checks++;
        if (obs_wen !== 4'b1000 || obs_wdata !== 32'hA5A5_A5A5) begin
            errors++; $display("FAIL sb_bus: got %b/%h required 1000/a5a5a5a5", obs_wen, obs_wdata);
        end
        model_expect(1'b0, 2'd0, 1'b0, 32'h13, 32'h0);
        do_access(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 0);
        checks++;
        if (obs_ren !== 1'b1 || obs_wen !== 4'h0 || obs_addr !== 32'h13) begin
            errors++; $display("FAIL lb_issue: got ren %b wen %b addr %h required 1/0000/13", obs_ren, obs_wen, obs_addr);
        end
        checks++;
        if (obs_rdata !== 32'hFFFF_FFA5 || obs_lat !== 3) begin
            errors++; $display("FAIL lb_rsp: got %h lat %0d required ffffffa5 lat 3", obs_rdata, obs_lat);
        end
    endtask

    task automatic test_half();
        model_expect(1'b1, 2'd2, 1'b0, 32'h10, 32'h8001_7FFF);
        do_access(1'b1, 2'd2, 1'b0, 32'h10, 32'h8001_7FFF, 0);
        model_expect(1'b0, 2'd1, 1'b1, 32'h12, 32'h0);
        do_access(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 0);
        checks++;
        if (obs_rdata !== 32'h0000_8001) begin
            errors++; $display("FAIL lhu: got %h required 00008001", obs_rdata);
        end
        model_expect(1'b0, 2'd1, 1'b0, 32'h12, 32'h0);
        do_access(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 0);
        checks++;
        if (obs_rdata !== 32'hFFFF_8001) begin
            errors++; $display("FAIL lh: got %h required ffff8001", obs_rdata);
        end
    endtask

    task automatic test_errors();
        logic [1:0]  szs [3] = '{2'd2, 2'd1, 2'd3};
        logic [31:0] ads [3] = '{32'h11, 32'h03, 32'h00};
        for (int i = 0; i < 3; i++) begin
            do_access(i[0], szs[i], 1'b0, ads[i], 32'h1234_5678, 0);
            checks++;
            if (obs_err !== 1'b1 || obs_rdata !== 32'h0 || obs_lat !== 1) begin
                errors++; $display("FAIL err_rsp%0d: got err %b data %h lat %0d required 1/0/1", i, obs_err, obs_rdata, obs_lat);
            end
            checks++;
            if (obs_wen !== 4'h0 || obs_ren !== 1'b0 || obs_stray !== 0) begin
                errors++; $display("FAIL err_strobe%0d: got wen %b ren %b stray %0d required none", i, obs_wen, obs_ren, obs_stray);
            end
        end
    endtask

    task automatic test_backpressure();
        model_expect(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        do_access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5);
        checks++;
        if (obs_rdata !== 32'h8001_7FFF || obs_unstable !== 0 || obs_busy !== 0) begin
            errors++; $display("FAIL bp_hold: got %h unstable %0d busy %0d required 80017fff/0/0", obs_rdata, obs_unstable, obs_busy);
        end
        checks++;
        if (obs_after_valid !== 1'b0 || obs_after_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release: got valid %b ready %b required 0/1", obs_after_valid, obs_after_ready);
        end
    endtask

    task automatic test_reset_mid();
        int bad;
        req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h20; req_wdata = 32'h1122_3344; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++;
        if (mem_wen !== 4'b1111) begin
            errors++; $display("FAIL rst_issue: got wen %b required 1111", mem_wen);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (mem_wen !== 4'h0 || mem_ren !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL rst_async: got wen %b ren %b valid %b required 0", mem_wen, mem_ren, rsp_valid);
        end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b0 || mem_wen !== 4'h0 || mem_ren !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL rst_after: got bad %0d ready %b required 0/1", bad, req_ready);
        end
    endtask

    task automatic test_random();
        logic        we, uns;
        logic [1:0]  sz;
        logic [31:0] addr, wd;
        for (int it = 0; it < 80; it++) begin
            we = 1'($urandom); uns = 1'($urandom); sz = 2'($urandom);
            addr = 32'($urandom_range(0, 255)); wd = $urandom;
            model_expect(we, sz, uns, addr, wd);
            do_access(we, sz, uns, addr, wd, int'($urandom_range(0, 3)));
            checks++;
            if (obs_timeout !== 1'b0) begin
                errors++; $display("FAIL rnd_timeout%0d: got timeout required response", it);
                continue;
            end
            checks++;
            if (obs_err !== e_err || obs_rdata !== e_rdata || obs_lat !== e_lat) begin
                errors++; $display("FAIL rnd_rsp%0d: got err %b data %h lat %0d required %b/%h/%0d (we %b sz %0d addr %h)",
                                   it, obs_err, obs_rdata, obs_lat, e_err, e_rdata, e_lat, we, sz, addr);
            end
            checks++;
            if (obs_wen !== (e_err ? 4'h0 : e_wen) || obs_ren !== (!e_err && !we) ||
                (!e_err && (obs_addr !== addr || obs_wdata !== e_wdata))) begin
                errors++; $display("FAIL rnd_issue%0d: got wen %b ren %b addr %h wd %h required %b/%b/%h/%h",
                                   it, obs_wen, obs_ren, obs_addr, obs_wdata, e_wen, !e_err && !we, addr, e_wdata);
            end
            checks++;
            if (obs_stray !== 0 || obs_unstable !== 0 || obs_busy !== 0 ||
                obs_after_valid !== 1'b0 || obs_after_ready !== 1'b1) begin
                errors++; $display("FAIL rnd_proto%0d: got stray %0d unstable %0d busy %0d after %b/%b required 0/0/0/0/1",
                                   it, obs_stray, obs_unstable, obs_busy, obs_after_valid, obs_after_ready);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram_b[i]   = 8'($urandom);
            ref_mem[i] = ram_b[i];
        end
        test_reset();
        test_store_word();
        test_byte();
        test_half();
        test_errors();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
